// File: rtl/constant_burst_source_pkg.sv
// constant_burst_source_pkg
//   Shared definitions for the constant burst source:
//   - state_t: FSM state encoding (IDLE = 0, RUN = 1)
//   - DEFAULT_WORD_WIDTH / DEFAULT_COUNT_WIDTH: default widths for the
//     emitted word and for the burst-length / stall counters.
package constant_burst_source_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WORD_WIDTH  = 8;
  localparam int DEFAULT_COUNT_WIDTH = 8;

endpackage

// File: rtl/burst_down_counter.sv
// burst_down_counter
//   Holds the number of words still to be emitted in the current burst.
//   Ports:
//     clock      in   rising-edge clock
//     clear      in   asynchronous active-high reset (count -> 0)
//     load       in   load load_value (takes priority over decrement)
//     load_value in   WIDTH  value to load
//     decrement  in   count down by one (ignored at zero)
//     count      out  WIDTH  current count
//     is_one     out  count == 1
//     is_zero    out  count == 0
module burst_down_counter
  import constant_burst_source_pkg::*;
#(
  parameter int WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic [WIDTH-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  assign is_one  = (count == WIDTH'(1));
  assign is_zero = (count == '0);

  // Decrement is blocked at zero so the count can never wrap to all-ones.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && !is_zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/constant_burst_source.sv
// constant_burst_source
//   Emits bursts of a constant word. A burst of start_length words is
//   requested through the start handshake; the words are then offered on
//   the constant_* stream, one per cycle when the consumer is ready.
//
//   Handshakes (both interfaces): a transfer happens on a rising clock edge
//   where valid && ready. start_ready is high exactly in IDLE;
//   constant_valid is high exactly in RUN and never drops without a
//   transfer of the final word.
//
//   Ports:
//     clock          in   rising-edge clock
//     clear          in   asynchronous active-high reset
//     start_valid    in   burst request offered
//     start_ready    out  burst request can be accepted (IDLE)
//     start_length   in   COUNT_WIDTH  words in the requested burst
//     constant_valid out  constant_out holds a word (RUN)
//     constant_ready in   consumer accepts the word
//     constant_out   out  WORD_WIDTH  always VALUE
//     burst_last     out  current word is the last of the burst
//     burst_done     out  one-cycle pulse in the first IDLE cycle after a burst
//                         (also one cycle after a zero-length request)
//     stall_count    out  COUNT_WIDTH  backpressure cycles in current/last burst
//     fsm_state      out  debug view of the FSM state (0 = IDLE, 1 = RUN)
//
//   Configuration:
//     CONSTANT_BURST_SOURCE_STALL_COUNT_EN  when defined, stall_count counts
//     RUN cycles with constant_ready low (saturating, cleared on each start
//     handshake); otherwise stall_count is tied to zero.
module constant_burst_source
  import constant_burst_source_pkg::*;
#(
  parameter int                    WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] VALUE       = '0,
  parameter int                    COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [COUNT_WIDTH-1:0] start_length,
  output logic                   constant_valid,
  input  logic                   constant_ready,
  output logic [WORD_WIDTH-1:0]  constant_out,
  output logic                   burst_last,
  output logic                   burst_done,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic                   fsm_state
);

  state_t                 state;
  logic                   start_fire;
  logic                   out_fire;
  logic                   last_fire;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   remaining_is_one;
  logic                   remaining_is_zero;

  // Stream outputs are pure decodes of registered state.
  assign start_ready    = (state == IDLE);
  assign constant_valid = (state == RUN);
  assign constant_out   = VALUE;
  assign burst_last     = constant_valid && remaining_is_one;
  assign fsm_state      = state;

  assign start_fire = start_valid && start_ready;
  assign out_fire   = constant_valid && constant_ready;
  // is_zero is a defensive exit: RUN with nothing left must not hang.
  assign last_fire  = out_fire && (remaining_is_one || remaining_is_zero);

  burst_down_counter #(
    .WIDTH(COUNT_WIDTH)
  ) u_remaining (
    .clock      (clock),
    .clear      (clear),
    .load       (start_fire),
    .load_value (start_length),
    .decrement  (out_fire),
    .count      (remaining),
    .is_one     (remaining_is_one),
    .is_zero    (remaining_is_zero)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      burst_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-length request completes immediately without entering RUN.
          burst_done <= start_fire && (start_length == '0);
          if (start_fire && (start_length != '0)) begin
            state <= RUN;
          end
        end
        RUN: begin
          burst_done <= last_fire;
          if (last_fire) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          burst_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONSTANT_BURST_SOURCE_STALL_COUNT_EN
  logic [COUNT_WIDTH-1:0] stall_q;

  // Counts RUN cycles without a transfer; holds its value after the burst
  // so it can be read once burst_done is seen.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stall_q <= '0;
    end else if (start_fire) begin
      stall_q <= '0;
    end else if (constant_valid && !constant_ready && (stall_q != '1)) begin
      stall_q <= stall_q + COUNT_WIDTH'(1);
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_constant_burst_source.sv
// tb_constant_burst_source
//   Bench for constant_burst_source (WORD_WIDTH=8, VALUE=8'hA5, COUNT_WIDTH=8).
//   Honours CONSTANT_BURST_SOURCE_STALL_COUNT_EN for the stall_count
//   expectations. The reference model tracks the burst at transaction level:
//   words still owed, a pending completion pulse and a stall tally.
module tb_constant_burst_source;

`ifdef CONSTANT_BURST_SOURCE_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  localparam logic [7:0] WORD = 8'hA5;

  // ---------------------------------------------------------------- clock/reset
  logic       clock = 1'b0;
  logic       clear;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] start_length;
  logic       constant_valid;
  logic       constant_ready;
  logic [7:0] constant_out;
  logic       burst_last;
  logic       burst_done;
  logic [7:0] stall_count;
  logic       fsm_state;

  always #5 clock = ~clock;

  constant_burst_source #(
    .WORD_WIDTH  (8),
    .VALUE       (8'hA5),
    .COUNT_WIDTH (8)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .start_length   (start_length),
    .constant_valid (constant_valid),
    .constant_ready (constant_ready),
    .constant_out   (constant_out),
    .burst_last     (burst_last),
    .burst_done     (burst_done),
    .stall_count    (stall_count),
    .fsm_state      (fsm_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model + scoreboard
  int         m_left  = 0;   // words still owed in the active burst
  bit         m_done  = 0;   // completion pulse expected this cycle
  int         m_stall = 0;   // backpressure cycles in current/last burst
  logic [7:0] exp_q[$];

  // Outputs are compared at the falling edge; the model then advances by the
  // inputs that the following rising edge will sample.
  always @(negedge clock) begin
    if (clear) begin
      m_left  = 0;
      m_done  = 0;
      m_stall = 0;
    end else begin
      bit nxt_done;
      check("start_ready", start_ready, m_left == 0);
      check("constant_valid", constant_valid, m_left > 0);
      check("burst_last", burst_last, m_left == 1);
      check("burst_done", burst_done, m_done);
      check("stall_count", stall_count, STALL_EN ? m_stall : 0);
      check("fsm_state", fsm_state, m_left > 0);

      nxt_done = 0;
      if (m_left > 0) begin
        if (constant_ready) begin
          exp_q.push_back(WORD);
          m_left--;
          if (m_left == 0) nxt_done = 1;
        end else if (m_stall < 255) begin
          m_stall++;
        end
      end else if (start_valid) begin
        m_stall = 0;
        if (start_length == 0) nxt_done = 1;
        else m_left = start_length;
      end

      if (constant_valid && constant_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 1, 0);
        else check("constant_out", constant_out, exp_q.pop_front());
      end
      m_done = nxt_done;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic idle_inputs();
    start_valid    = 1'b0;
    start_length   = 8'd0;
    constant_ready = 1'b1;
  endtask

  // Offers one request for a single cycle; returns 1 time unit after the
  // accepting edge (i.e. during the first cycle of the burst).
  task automatic do_start(input logic [7:0] len);
    @(posedge clock); #1;
    start_valid  = 1'b1;
    start_length = len;
    @(posedge clock); #1;
    start_valid  = 1'b0;
    start_length = $urandom_range(0, 255);  // ignored outside IDLE
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      idle_inputs();
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int xfers;
    clear = 1'b1;
    idle_inputs();
    #2;
    check("reset_valid", constant_valid, 0);
    check("reset_last", burst_last, 0);
    check("reset_done", burst_done, 0);
    check("reset_stall", stall_count, 0);
    check("reset_start_ready", start_ready, 1);
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    settle(2);

    // Four words back to back, last on the fourth, done right after.
    do_start(8'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("b4_valid", constant_valid, 1);
      check("b4_word", constant_out, 8'hA5);
      check("b4_last", burst_last, k == 3);
    end
    @(negedge clock);
    check("b4_done", burst_done, 1);
    check("b4_valid_after", constant_valid, 0);
    settle(2);

    // Three words with ready low on RUN cycles 2 and 3.
    do_start(8'd3);
    xfers = 0;
    for (int k = 0; k < 5; k++) begin
      constant_ready = !(k == 1 || k == 2);
      @(negedge clock);
      check("b3_valid", constant_valid, 1);
      if (constant_valid && constant_ready) xfers++;
      @(posedge clock); #1;
    end
    check("b3_xfers", xfers, 3);
    @(negedge clock);
    check("b3_done", burst_done, 1);
    check("b3_stall", stall_count, STALL_EN ? 2 : 0);
    settle(2);

    // Zero-length request: no words, one done pulse, stays ready.
    do_start(8'd0);
    @(negedge clock);
    check("b0_done", burst_done, 1);
    check("b0_valid", constant_valid, 0);
    check("b0_start_ready", start_ready, 1);
    @(negedge clock);
    check("b0_done_once", burst_done, 0);
    check("b0_start_ready2", start_ready, 1);
    settle(2);

    // Long burst under full backpressure: stall count saturates.
    constant_ready = 1'b0;
    do_start(8'd255);
    constant_ready = 1'b0;
    xfers = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (!constant_valid) xfers++;
    end
    check("b255_valid_drops", xfers, 0);
    check("b255_stall", stall_count, STALL_EN ? 255 : 0);
    settle(260);

    // Clear after two of five words: async return to IDLE, no done pulse.
    do_start(8'd5);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock); #3;
    clear = 1'b1;
    #1;
    check("clr_valid", constant_valid, 0);
    check("clr_last", burst_last, 0);
    check("clr_done", burst_done, 0);
    check("clr_stall", stall_count, 0);
    check("clr_start_ready", start_ready, 1);
    check("clr_state", fsm_state, 0);
    @(posedge clock); #1;
    clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("clr_no_done", burst_done, 0);
    end
    settle(1);

    // start_valid held: second burst accepted in the done cycle.
    start_valid  = 1'b1;
    start_length = 8'd2;
    @(posedge clock); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("b2b_valid", constant_valid, k != 2);
      check("b2b_done", burst_done, k == 2);
      check("b2b_start_ready", start_ready, k == 2);
    end
    @(posedge clock); #1;
    start_valid = 1'b0;
    settle(4);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #1;
      start_valid    = ($urandom_range(0, 3) == 0);
      start_length   = $urandom_range(0, 9);
      if ($urandom_range(0, 40) == 0) start_length = $urandom_range(0, 255);
      constant_ready = ($urandom_range(0, 2) != 0);
    end
    settle(300);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
